// File: rtl/sd_block_arbiter_if.sv
// sd_block_arbiter_if: start handshake and byte stream between the arbiter and sd_controller
// master: arbiter side, drives sd_rd/sd_wr/sd_din/sd_address, receives dout and strobes
// slave: controller side, mirror of master
interface sd_block_arbiter_if;
   logic       sd_rd;
   logic       sd_wr;
   logic [7:0] sd_din;
   logic [31:0] sd_address;
   logic [7:0] sd_dout;
   logic       sd_byte_available;
   logic       sd_ready;
   logic       sd_ready_for_next_byte;
   modport master (
      output sd_rd, sd_wr, sd_din, sd_address,
      input  sd_dout, sd_byte_available, sd_ready, sd_ready_for_next_byte
   );
   modport slave (
      input  sd_rd, sd_wr, sd_din, sd_address,
      output sd_dout, sd_byte_available, sd_ready, sd_ready_for_next_byte
   );
endinterface

// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin two-requester sector sequencer in front of sd_controller
// clk/reset: shared clock, synchronous active-high reset
// req_rd/req_wr/req_addr_*/req_wdata_*: per-requester sector requests and write bytes
// grant/wdata_take/rdata/rdata_valid/done/err: per-requester handshake and status
// sd: controller start handshake and byte strobes
module sd_block_arbiter #(
   parameter int START_TIMEOUT = 1024,
   parameter int BLOCK_BYTES   = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_rd,
   input  logic [1:0]  req_wr,
   input  logic [31:0] req_addr_0,
   input  logic [31:0] req_addr_1,
   input  logic [7:0]  req_wdata_0,
   input  logic [7:0]  req_wdata_1,
   output logic [1:0]  grant,
   output logic [1:0]  wdata_take,
   output logic [7:0]  rdata,
   output logic [1:0]  rdata_valid,
   output logic [1:0]  done,
   output logic        err,
   sd_block_arbiter_if.master sd
);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;
   state_t state_q, state_d;
   logic last_q, last_d, g_q, g_d, op_wr_q, op_wr_d, sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d, err_q, err_d;
   logic [1:0] grant_q, grant_d, wdata_take_q, wdata_take_d, rdata_valid_q, rdata_valid_d, done_q, done_d;
   logic [7:0] rdata_q, rdata_d, sd_din_q, sd_din_d;
   logic [31:0] sd_address_q, sd_address_d;
   logic [9:0] byte_cnt_q, byte_cnt_d, byte_inc;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0] req;
   logic w, xfer_pulse;
   assign req        = req_rd | req_wr;
   // on a tie the requester not served last wins; otherwise the only requester wins
   assign w          = &req ? ~last_q : req[1];
   assign byte_inc   = &byte_cnt_q ? byte_cnt_q : byte_cnt_q + 10'd1;
   assign xfer_pulse = op_wr_q ? sd.sd_ready_for_next_byte : sd.sd_byte_available;
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      g_d           = g_q;
      grant_d       = grant_q;
      op_wr_d       = op_wr_q;
      sd_rd_d       = sd_rd_q;
      sd_wr_d       = sd_wr_q;
      sd_din_d      = sd_din_q;
      sd_address_d  = sd_address_q;
      rdata_d       = rdata_q;
      byte_cnt_d    = byte_cnt_q;
      tmo_d         = tmo_q;
      wdata_take_d  = '0;
      rdata_valid_d = '0;
      done_d        = '0;
      err_d         = 1'b0;
      case (state_q)
         IDLE: if (sd.sd_ready && |req) begin
            state_d      = START;
            g_d          = w;
            grant_d      = {w, ~w};
            op_wr_d      = ~req_rd[w];
            sd_rd_d      = req_rd[w];
            sd_wr_d      = ~req_rd[w];
            sd_address_d = w ? req_addr_1 : req_addr_0;
            byte_cnt_d   = '0;
            tmo_d        = '0;
            // the first write byte is handed over with the command, not by a strobe
            if (!req_rd[w]) begin
               sd_din_d     = w ? req_wdata_1 : req_wdata_0;
               wdata_take_d = {w, ~w};
            end
         end
         START: if (!sd.sd_ready) begin
            sd_rd_d = 1'b0;
            sd_wr_d = 1'b0;
            state_d = XFER;
         end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
            sd_rd_d = 1'b0;
            sd_wr_d = 1'b0;
            state_d = DONE;
            done_d  = grant_q;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
         XFER: begin
            if (xfer_pulse) begin
               byte_cnt_d    = byte_inc;
               sd_din_d      = op_wr_q ? (g_q ? req_wdata_1 : req_wdata_0) : sd_din_q;
               rdata_d       = op_wr_q ? rdata_q : sd.sd_dout;
               wdata_take_d  = op_wr_q ? grant_q : 2'b00;
               rdata_valid_d = op_wr_q ? 2'b00 : grant_q;
            end
            // writes see one strobe fewer than bytes because the first byte went with the command
            if (sd.sd_ready) begin
               state_d = DONE;
               done_d  = grant_q;
               err_d   = byte_cnt_d != (op_wr_q ? 10'(BLOCK_BYTES - 1) : 10'(BLOCK_BYTES));
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = g_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         last_q        <= 1'b1;
         g_q           <= 1'b0;
         grant_q       <= '0;
         op_wr_q       <= 1'b0;
         sd_rd_q       <= 1'b0;
         sd_wr_q       <= 1'b0;
         sd_din_q      <= '0;
         sd_address_q  <= '0;
         rdata_q       <= '0;
         byte_cnt_q    <= '0;
         tmo_q         <= '0;
         wdata_take_q  <= '0;
         rdata_valid_q <= '0;
         done_q        <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         g_q           <= g_d;
         grant_q       <= grant_d;
         op_wr_q       <= op_wr_d;
         sd_rd_q       <= sd_rd_d;
         sd_wr_q       <= sd_wr_d;
         sd_din_q      <= sd_din_d;
         sd_address_q  <= sd_address_d;
         rdata_q       <= rdata_d;
         byte_cnt_q    <= byte_cnt_d;
         tmo_q         <= tmo_d;
         wdata_take_q  <= wdata_take_d;
         rdata_valid_q <= rdata_valid_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end
   assign grant         = grant_q;
   assign wdata_take    = wdata_take_q;
   assign rdata         = rdata_q;
   assign rdata_valid   = rdata_valid_q;
   assign done          = done_q;
   assign err           = err_q;
   assign sd.sd_rd      = sd_rd_q;
   assign sd.sd_wr      = sd_wr_q;
   assign sd.sd_din     = sd_din_q;
   assign sd.sd_address = sd_address_q;
endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter: randomized sector traffic against a behavioural controller and arbitration model
module tb_sd_block_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0] req_rd = '0, req_wr = '0;
   logic [31:0] req_addr_0 = '0, req_addr_1 = '0;
   logic [7:0] req_wdata_0 = '0, req_wdata_1 = '0;
   logic [1:0] grant, wdata_take, rdata_valid, done;
   logic [7:0] rdata;
   logic err;
   int checks = 0;
   int errors = 0;
   bit last_m = 1'b1;
   sd_block_arbiter_if sd();
   sd_block_arbiter #(.START_TIMEOUT(1024), .BLOCK_BYTES(512)) dut (
      .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
      .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
      .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
      .grant(grant), .wdata_take(wdata_take), .rdata(rdata), .rdata_valid(rdata_valid),
      .done(done), .err(err), .sd(sd)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic set_wd(input bit r, input logic [7:0] v);
      if (r) req_wdata_1 = v;
      else req_wdata_0 = v;
   endtask
   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_take"}, wdata_take, 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_rvalid"}, rdata_valid, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_sd_rd"}, sd.sd_rd, 0);
      chk({tag, "_sd_wr"}, sd.sd_wr, 0);
      chk({tag, "_sd_din"}, sd.sd_din, 0);
      chk({tag, "_sd_addr"}, sd.sd_address, 0);
   endtask
   // One sector: the winner and its operation come from the round-robin rule, the
   // controller is emulated byte by byte; rst_at >= 0 aborts with a reset at that byte.
   task automatic sector(input int nbytes, input bit respond, input logic [7:0] seed, input int rst_at);
      logic [1:0] req, g;
      logic [31:0] a;
      logic [7:0] d;
      logic [7:0] wq[$];
      bit w, wr;
      int n, k, cnt;
      req = req_rd | req_wr;
      w   = (&req) ? ~last_m : req[1];
      g   = w ? 2'b10 : 2'b01;
      wr  = !req_rd[w];
      a   = w ? req_addr_1 : req_addr_0;
      for (int i = 0; i <= nbytes; i++) wq.push_back(8'($urandom));
      set_wd(w, wq[0]);
      n = 0;
      while (grant == 2'b00 && n < 20) begin
         tick;
         n++;
      end
      chk("grant", grant, g);
      chk("sd_address", sd.sd_address, a);
      chk("sd_rd", sd.sd_rd, !wr);
      chk("sd_wr", sd.sd_wr, wr);
      if (wr) begin
         chk("din_first", sd.sd_din, wq[0]);
         chk("take_first", wdata_take, g);
      end
      req_rd[w] = 1'b0;
      req_wr[w] = 1'b0;
      k = 1;
      set_wd(w, wq[k]);
      if (!respond) begin
         n = 1;
         while ((sd.sd_rd | sd.sd_wr) && n < 2000) begin
            tick;
            n += int'(sd.sd_rd | sd.sd_wr);
         end
         chk("tmo_cycles", n, 1024);
         chk("tmo_done", done, g);
         chk("tmo_err", err, 1);
      end else begin
         sd.sd_ready = 1'b0;
         tick;
         chk("start_clear", sd.sd_rd | sd.sd_wr, 0);
         cnt = wr ? nbytes - 1 : nbytes;
         for (int i = 0; i < cnt; i++) begin
            if (i == rst_at) begin
               reset = 1'b1;
               tick;
               chk_all_zero("midrst");
               reset = 1'b0;
               sd.sd_ready = 1'b1;
               last_m = 1'b1;
               tick;
               chk("midrst_nodone", done, 0);
               return;
            end
            d = 8'(seed + i);
            if (wr) sd.sd_ready_for_next_byte = 1'b1;
            else begin
               sd.sd_dout = d;
               sd.sd_byte_available = 1'b1;
            end
            tick;
            sd.sd_ready_for_next_byte = 1'b0;
            sd.sd_byte_available = 1'b0;
            if (wr) begin
               chk("take", wdata_take, g);
               chk("din", sd.sd_din, wq[k]);
               k++;
               set_wd(w, wq[k]);
            end else begin
               chk("rvalid", rdata_valid, g);
               chk("rdata", rdata, d);
            end
            repeat ($urandom_range(0, 2)) begin
               tick;
               chk("gap_quiet", wdata_take | rdata_valid, 0);
            end
         end
         sd.sd_ready = 1'b1;
         tick;
         chk("done", done, g);
         chk("err", err, nbytes != 512);
         chk("grant_at_done", grant, g);
      end
      tick;
      chk("done_clear", done, 0);
      chk("grant_clear", grant, 0);
      last_m = w;
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end
   initial begin
      int m;
      sd.sd_ready = 1'b0;
      sd.sd_dout = '0;
      sd.sd_byte_available = 1'b0;
      sd.sd_ready_for_next_byte = 1'b0;
      tick;
      tick;
      chk_all_zero("reset");
      reset = 1'b0;
      // controller still initialising: no grant, stray strobes ignored
      req_rd[0] = 1'b1;
      req_addr_0 = 32'h0000_0010;
      repeat (4) tick;
      chk("init_nogrant", grant, 0);
      sd.sd_byte_available = 1'b1;
      sd.sd_ready_for_next_byte = 1'b1;
      tick;
      sd.sd_byte_available = 1'b0;
      sd.sd_ready_for_next_byte = 1'b0;
      chk("idle_pulse_ignored", rdata_valid | wdata_take, 0);
      sd.sd_ready = 1'b1;
      sector(512, 1'b1, 8'h00, -1);
      req_wr[1] = 1'b1;
      req_addr_1 = $urandom;
      sector(512, 1'b1, 8'h00, -1);
      // contention twice, then requester 0 keeps requesting
      for (int r = 0; r < 2; r++) begin
         req_rd = 2'b11;
         req_addr_0 = $urandom;
         req_addr_1 = $urandom;
         sector(64, 1'b1, 8'($urandom), -1);
         sector(64, 1'b1, 8'($urandom), -1);
      end
      req_rd = 2'b11;
      for (int r = 0; r < 4; r++) begin
         req_rd[0] = 1'b1;
         sector(32, 1'b1, 8'($urandom), -1);
      end
      req_rd = 2'b00;
      req_wr = 2'b00;
      for (int it = 0; it < 8; it++) begin
         for (int r = 0; r < 2; r++) if (!(req_rd[r] | req_wr[r])) begin
            m = $urandom_range(0, 3);
            req_rd[r] = m[0];
            req_wr[r] = m[1];
            if (r == 1) req_addr_1 = $urandom;
            else req_addr_0 = $urandom;
         end
         if ((req_rd | req_wr) == 2'b00) req_rd[0] = 1'b1;
         sector($urandom_range(0, 1) == 1 ? 512 : $urandom_range(1, 60), 1'b1, 8'($urandom), -1);
      end
      for (int r = 0; r < 2 && (req_rd | req_wr) != 2'b00; r++) sector(8, 1'b1, 8'($urandom), -1);
      req_rd[1] = 1'b1;
      sector(1, 1'b0, 8'h00, -1);
      req_rd[0] = 1'b1;
      sector(100, 1'b1, 8'($urandom), -1);
      req_rd[0] = 1'b1;
      sector(512, 1'b1, 8'($urandom), 200);
      req_wr[1] = 1'b1;
      sector(512, 1'b1, 8'($urandom), -1);
      req_rd = 2'b11;
      sector(16, 1'b1, 8'($urandom), -1);
      sector(512, 1'b1, 8'($urandom), -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
